// File: rtl/mux_arb.sv
// Round-robin 2:1 mux arbiter with registered grants and select.
// Define MUX_ARB_TIMEOUT_EN to enable the HOLD_MAX hold limit and timeout pulse.
module mux_arb #(
  parameter int HOLD_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux_arb: HOLD_MAX must be in 1..255");
  end

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   last_b_q, last_b_d;
  logic   timeout_q, timeout_d;
  logic   owner_req;
  logic   limit;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q, hold_d;

  assign limit = (hold_q == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign limit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_b_d  = last_b_q;
    timeout_d = 1'b0;
    owner_req = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie A wins only when B was granted last.
        if (req_a && (!req_b || last_b_q)) begin
          state_d  = GNT_A;
          sel_d    = 1'b0;
          last_b_d = 1'b0;
        end else if (req_b) begin
          state_d  = GNT_B;
          sel_d    = 1'b1;
          last_b_d = 1'b1;
        end
      end
      GNT_A, GNT_B: begin
        owner_req = (state_q == GNT_A) ? req_a : req_b;
        if (done || !owner_req) begin
          state_d = IDLE;
        end else if (limit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d = (state_q != IDLE && state_d != IDLE) ? hold_q + 8'd1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_b_q  <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_b_q  <= last_b_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_a   = (state_q == GNT_A);
  assign gnt_b   = (state_q == GNT_B);
  assign busy    = gnt_a | gnt_b;
  assign sel     = sel_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: vector table, hold-limit sequences, random vs reference model.
module tb_mux_arb;

  localparam int HM = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_a, req_b, done;
  logic sel, gnt_a, gnt_b, busy, timeout;
  logic sel1, gnt_a1, gnt_b1, busy1, timeout1;

  mux_arb #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .timeout(timeout)
  );

  mux_arb #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(sel1), .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1), .timeout(timeout1)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0=none 1=A 2=B, held = grant cycles already shown.
  int m_owner = 0;
  int m_last  = 2;
  int m_held  = 0;
  bit m_sel   = 1'b0;
  bit m_to    = 1'b0;

  function automatic void model_step(bit r, bit ra, bit rb, bit d);
    int w;
    bit mine, lim;
    w = 0;
    if (r) begin
      m_owner = 0; m_last = 2; m_sel = 1'b0; m_held = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner == 0) begin
      if (ra && rb)  w = (m_last == 1) ? 2 : 1;
      else if (ra)   w = 1;
      else if (rb)   w = 2;
      if (w != 0) begin
        m_owner = w; m_last = w; m_sel = (w == 2); m_held = 1;
      end
    end else begin
      mine = (m_owner == 1) ? ra : rb;
      lim  = TO_EN && (m_held >= HM);
      if (d || !mine || lim) begin
        m_to    = lim && !d && mine;
        m_owner = 0;
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit ra, input bit rb, input bit d);
    rst = r; req_a = ra; req_b = rb; done = d;
    @(posedge clk);
    model_step(r, ra, rb, d);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_bit({tag, "_gnt_a"}, gnt_a, m_owner == 1);
    check_bit({tag, "_gnt_b"}, gnt_b, m_owner == 2);
    check_bit({tag, "_sel"}, sel, m_sel);
    check_bit({tag, "_busy"}, busy, m_owner != 0);
    check_bit({tag, "_timeout"}, timeout, m_to);
    check_bit({tag, "_excl"}, gnt_a & gnt_b, 1'b0);
  endtask

  typedef struct {
    bit r, ra, rb, d;
    bit ga, gb, s, to;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done = 1'b0;

    //          r  ra rb d   ga gb s  to
    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0,  1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1,  0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 0,  0, 1, 1, 0};
    tbl[4]  = '{0, 1, 1, 1,  0, 0, 1, 0};
    tbl[5]  = '{0, 1, 1, 0,  1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0,  0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0,  0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1,  0, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 0,  0, 1, 1, 0};
    tbl[11] = '{1, 1, 1, 0,  0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0,  1, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0,  0, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].ra, tbl[i].rb, tbl[i].d);
      check_bit($sformatf("vec%0d_gnt_a", i), gnt_a, tbl[i].ga);
      check_bit($sformatf("vec%0d_gnt_b", i), gnt_b, tbl[i].gb);
      check_bit($sformatf("vec%0d_sel", i), sel, tbl[i].s);
      check_bit($sformatf("vec%0d_busy", i), busy, tbl[i].ga | tbl[i].gb);
      check_bit($sformatf("vec%0d_timeout", i), timeout, tbl[i].to);
    end

`ifdef MUX_ARB_TIMEOUT_EN
    // req_a held: HOLD_MAX=4 grants 4 cycles then a timeout/idle cycle; HOLD_MAX=1 alternates.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, 0, 0);
      check_bit($sformatf("hold4_c%0d_gnt_a", i), gnt_a, (i % 5) != 4);
      check_bit($sformatf("hold4_c%0d_timeout", i), timeout, (i % 5) == 4);
      check_bit($sformatf("hold1_c%0d_gnt_a", i), gnt_a1, (i % 2) == 0);
      check_bit($sformatf("hold1_c%0d_timeout", i), timeout1, (i % 2) == 1);
    end
    // done coinciding with the hold limit releases without a timeout pulse.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    check_bit("limit_done_pre_gnt_a", gnt_a, 1'b1);
    drive(0, 1, 0, 1);
    check_bit("limit_done_gnt_a", gnt_a, 1'b0);
    check_bit("limit_done_timeout", timeout, 1'b0);
`else
    drive(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 0, 0);
      check_bit($sformatf("nolimit_c%0d_gnt_a", i), gnt_a, 1'b1);
      check_bit($sformatf("nolimit_c%0d_timeout", i), timeout, 1'b0);
      check_bit($sformatf("nolimit1_c%0d_gnt_a", i), gnt_a1, 1'b1);
      check_bit($sformatf("nolimit1_c%0d_timeout", i), timeout1, 1'b0);
    end
`endif

    drive(1, 0, 0, 0);
    check_model("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(3) != 0,
            $urandom_range(3) != 0, $urandom_range(5) == 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
